action_select_controller: RTL and testbench
===========================================

Name: action_select_controller

Overview:
- Sequences the main-net argument-max unit for one decision per environment step.
- Collects the NUMBER_OF_OUTPUT_NODE Q-values from the main-net output layer and forwards them to the argmax unit.
- Waits for the argmax result, then applies epsilon-greedy selection using an internal LFSR.
- Presents the chosen action to the environment/replay logic with a valid/ready handshake; sits between the main-net output stage and the agent top-level.

Parameters:
- DATA_WIDTH, 32, Q-value width (IEEE-754 single).
- NUMBER_OF_OUTPUT_NODE, 3, number of actions / Q-values per decision.
- DATA_COUNTER_WIDTH, 5, width of Q-value address.
- ACTION_WIDTH, 2, width of action index.
- EPS_WIDTH, 16, width of epsilon threshold and LFSR.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for argmax result.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- i_start  in  1  begin a decision (pulse)
- i_epsilon  in  EPS_WIDTH  exploration threshold, sampled at i_start
- i_q_valid  in  1  Q-value beat valid
- i_q_addr  in  DATA_COUNTER_WIDTH  Q-value index
- i_q_data  in  DATA_WIDTH  Q-value
- o_am_valid  out  1  beat to argmax unit
- o_am_addr  out  DATA_COUNTER_WIDTH  beat index to argmax unit
- o_am_data  out  DATA_WIDTH  beat data to argmax unit
- i_am_arg_max  in  ACTION_WIDTH  argmax result
- i_am_valid  in  1  argmax result valid
- o_action  out  ACTION_WIDTH  selected action
- o_action_valid  out  1  action valid
- i_action_ready  in  1  consumer accepts action
- o_explore  out  1  selected action is random; qualified by o_action_valid
- o_busy  out  1  decision in progress (state != IDLE)
- o_error  out  1  sticky: timeout or bad address; cleared by next accepted i_start

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; LFSR = LFSR_SEED; counters 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle including IDLE; never all-zero.
- States: IDLE, LOAD, WAIT_AM, DECIDE, HOLD.
- IDLE:
  - i_start=1 -> latch i_epsilon, clear o_error, beat_cnt=0, go to LOAD.
  - i_q_valid in IDLE is ignored, not forwarded.
- LOAD:
  - Each i_q_valid beat with i_q_addr < N is registered to o_am_* with exactly 1-cycle latency; beat_cnt++.
  - A beat with i_q_addr >= N is dropped and sets o_error.
  - When beat_cnt reaches N -> WAIT_AM and timer=0.
  - Duplicate addresses are forwarded and counted; no check.
- WAIT_AM:
  - i_am_valid -> latch i_am_arg_max, go to DECIDE.
  - timer == TIMEOUT_CYCLES-1 without valid -> o_error=1, go to IDLE, no action issued.
  - i_am_valid outside WAIT_AM is ignored.
- DECIDE (one cycle):
  - explore = (lfsr < eps_latched), unsigned compare.
  - rnd = lfsr[ACTION_WIDTH-1:0]; if rnd >= N then rnd = rnd - N.
  - o_action = explore ? rnd : greedy; o_explore = explore; o_action_valid=1; go to HOLD.
  - eps=0 never explores; eps=all-ones explores except when lfsr is all-ones.
- HOLD:
  - o_action, o_explore and o_action_valid held stable until i_action_ready=1.
  - Transfer occurs on the cycle valid&&ready; next cycle o_action_valid=0 and state IDLE.
- i_start while busy is ignored.
- Latency: last Q beat -> o_am beat +1 cycle; i_am_valid -> o_action_valid +2 cycles (latch, DECIDE register).
- rst asserted mid-operation returns to IDLE in the next cycle; no pending o_am_valid or o_action_valid survives.

Decomposition:
- Shared package: state encoding constants, LFSR tap mask, default seed.
- Natural sub-module: lfsr16, a free-running LFSR with seed parameter and enable.

Test Plan:
- Greedy path: eps=0, Q={1.0 (32'h3F800000), 3.0 (32'h40400000), 2.0 (32'h40000000)}, model argmax returns 1 -> o_action=1, o_explore=0, valid 2 cycles after i_am_valid.
- Explore path: eps=16'hFFFF, seed such that lfsr[1:0]=3 at DECIDE -> o_action=0 (3-3), o_explore=1; over 1000 decisions the action counts are all non-zero.
- Backpressure: hold i_action_ready=0 for 10 cycles -> o_action and o_explore stable and valid held; ready=1 -> single transfer, then IDLE.
- Timeout: argmax model never responds -> o_error=1 after 64 cycles in WAIT_AM, no o_action_valid; next i_start clears o_error.
- Bad address plus ignored start: beat with addr=5 -> dropped, o_error=1, not forwarded; i_start pulsed during LOAD has no effect.
- Reset mid-HOLD: assert rst while o_action_valid=1 -> all outputs 0 next cycle, state IDLE, LFSR = seed.

Source files
------------

// File: rtl/action_select_controller_pkg.sv
// Shared types and constants for the epsilon-greedy action selector.
package action_select_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_AM,
    S_DECIDE,
    S_HOLD
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/action_select_controller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR with seed and enable.
module lfsr16
  import action_select_controller_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);

  // all-zero is a lock-up state; reload the seed if it is ever seen
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED;
    end else if (en) begin
      value <= (value == '0) ? SEED : lfsr_next(value);
    end
  end

endmodule

// File: rtl/action_select_controller.sv
// Collects Q-values, drives the argmax unit, then picks an action epsilon-greedily.
module action_select_controller
  import action_select_controller_pkg::*;
#(
  parameter int          DATA_WIDTH            = 32,
  parameter int          NUMBER_OF_OUTPUT_NODE = 3,
  parameter int          DATA_COUNTER_WIDTH    = 5,
  parameter int          ACTION_WIDTH          = 2,
  parameter int          EPS_WIDTH             = 16,
  parameter logic [15:0] LFSR_SEED             = LFSR_SEED_DEFAULT,
  parameter int          TIMEOUT_CYCLES        = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [EPS_WIDTH-1:0]          i_epsilon,
  input  logic                          i_q_valid,
  input  logic [DATA_COUNTER_WIDTH-1:0] i_q_addr,
  input  logic [DATA_WIDTH-1:0]         i_q_data,
  output logic                          o_am_valid,
  output logic [DATA_COUNTER_WIDTH-1:0] o_am_addr,
  output logic [DATA_WIDTH-1:0]         o_am_data,
  input  logic [ACTION_WIDTH-1:0]       i_am_arg_max,
  input  logic                          i_am_valid,
  output logic [ACTION_WIDTH-1:0]       o_action,
  output logic                          o_action_valid,
  input  logic                          i_action_ready,
  output logic                          o_explore,
  output logic                          o_busy,
  output logic                          o_error
);

  localparam int N  = NUMBER_OF_OUTPUT_NODE;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                        state_q, state_d;
  logic [DATA_COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [TW-1:0]                 timer_q, timer_d;
  logic [EPS_WIDTH-1:0]          eps_q, eps_d;
  logic [ACTION_WIDTH-1:0]       greedy_q, greedy_d;
  logic [ACTION_WIDTH-1:0]       rnd;
  logic [15:0]                   lfsr;
  logic                          explore;

  logic                          am_valid_d;
  logic [DATA_COUNTER_WIDTH-1:0] am_addr_d;
  logic [DATA_WIDTH-1:0]         am_data_d;
  logic [ACTION_WIDTH-1:0]       action_d;
  logic                          act_valid_d;
  logic                          explore_d;
  logic                          error_d;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .value (lfsr)
  );

  assign explore = (lfsr < eps_q);

  // fold out-of-range random indices back into the action set
  always_comb begin
    rnd = lfsr[ACTION_WIDTH-1:0];
    if (int'(rnd) >= N) begin
      rnd = rnd - ACTION_WIDTH'(N);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    eps_d       = eps_q;
    greedy_d    = greedy_q;
    am_valid_d  = 1'b0;
    am_addr_d   = o_am_addr;
    am_data_d   = o_am_data;
    action_d    = o_action;
    act_valid_d = o_action_valid;
    explore_d   = o_explore;
    error_d     = o_error;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          eps_d   = i_epsilon;
          error_d = 1'b0;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (i_q_valid) begin
          if (int'(i_q_addr) < N) begin
            am_valid_d = 1'b1;
            am_addr_d  = i_q_addr;
            am_data_d  = i_q_data;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == DATA_COUNTER_WIDTH'(N - 1)) begin
              timer_d = '0;
              state_d = S_WAIT_AM;
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_WAIT_AM: begin
        if (i_am_valid) begin
          greedy_d = i_am_arg_max;
          state_d  = S_DECIDE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DECIDE: begin
        action_d    = explore ? rnd : greedy_q;
        explore_d   = explore;
        act_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (i_action_ready) begin
          act_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      timer_q        <= '0;
      eps_q          <= '0;
      greedy_q       <= '0;
      o_am_valid     <= 1'b0;
      o_am_addr      <= '0;
      o_am_data      <= '0;
      o_action       <= '0;
      o_action_valid <= 1'b0;
      o_explore      <= 1'b0;
      o_error        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      timer_q        <= timer_d;
      eps_q          <= eps_d;
      greedy_q       <= greedy_d;
      o_am_valid     <= am_valid_d;
      o_am_addr      <= am_addr_d;
      o_am_data      <= am_data_d;
      o_action       <= action_d;
      o_action_valid <= act_valid_d;
      o_explore      <= explore_d;
      o_error        <= error_d;
    end
  end

  assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_action_select_controller.sv
// Directed and randomized checks of action_select_controller against a rule-level model.
module tb_action_select_controller;

  localparam int          DW   = 32;
  localparam int          N    = 3;
  localparam int          CW   = 5;
  localparam int          AW   = 2;
  localparam int          EW   = 16;
  localparam int          TO   = 64;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [EW-1:0] i_epsilon;
  logic          i_q_valid;
  logic [CW-1:0] i_q_addr;
  logic [DW-1:0] i_q_data;
  logic          o_am_valid;
  logic [CW-1:0] o_am_addr;
  logic [DW-1:0] o_am_data;
  logic [AW-1:0] i_am_arg_max;
  logic          i_am_valid;
  logic [AW-1:0] o_action;
  logic          o_action_valid;
  logic          i_action_ready;
  logic          o_explore;
  logic          o_busy;
  logic          o_error;

  int          checks = 0;
  int          errors = 0;
  int          hist[N];
  logic [31:0] qv[N];
  logic [15:0] m_lfsr;
  logic [AW-1:0] act;

  action_select_controller dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_epsilon      (i_epsilon),
    .i_q_valid      (i_q_valid),
    .i_q_addr       (i_q_addr),
    .i_q_data       (i_q_data),
    .o_am_valid     (o_am_valid),
    .o_am_addr      (o_am_addr),
    .o_am_data      (o_am_data),
    .i_am_arg_max   (i_am_arg_max),
    .i_am_valid     (i_am_valid),
    .o_action       (o_action),
    .o_action_valid (o_action_valid),
    .i_action_ready (i_action_ready),
    .o_explore      (o_explore),
    .o_busy         (o_busy),
    .o_error        (o_error)
  );

  always #5 clk = ~clk;

  // polynomial taps given 1-based: x^16 + x^14 + x^13 + x^11 + 1
  function automatic logic [15:0] step(input logic [15:0] v);
    int   taps[4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= v[taps[i]-1];
    return {v[14:0], fb};
  endfunction

  always @(posedge clk) m_lfsr <= rst ? SEED : step(m_lfsr);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int addr, input logic [31:0] d, input bit fwd);
    i_q_valid = 1'b1;
    i_q_addr  = CW'(addr);
    i_q_data  = d;
    tick();
    i_q_valid = 1'b0;
    chk("am_valid", o_am_valid, fwd);
    if (fwd) begin
      chk("am_addr", o_am_addr, addr);
      chk("am_data", o_am_data, d);
    end
  endtask

  task automatic start_load(input logic [15:0] eps);
    i_start   = 1'b1;
    i_epsilon = eps;
    tick();
    i_start   = 1'b0;
    i_epsilon = '0;
    chk("busy_load", o_busy, 1);
    chk("err_clr", o_error, 0);
    for (int k = 0; k < N; k++) beat(k, qv[k], 1'b1);
  endtask

  task automatic decide(input logic [15:0] eps, input logic [AW-1:0] greedy,
                        input int am_wait, input int rdy_wait,
                        input bit want3, output logic [AW-1:0] got);
    logic [15:0]   l;
    bit            exp_x;
    logic [AW-1:0] exp_a;
    int            n;
    start_load(eps);
    repeat (am_wait) tick();
    if (want3) begin
      l = step(m_lfsr);
      for (n = 0; n < 20 && l[1:0] != 2'd3; n++) begin
        tick();
        l = step(m_lfsr);
      end
      chk("align3", l[1:0], 3);
    end
    i_am_valid   = 1'b1;
    i_am_arg_max = greedy;
    tick();
    i_am_valid = 1'b0;
    l = m_lfsr;
    chk("early_valid", o_action_valid, 0);
    tick();
    exp_x = (l < eps);
    exp_a = exp_x ? AW'((l % 4) % N) : greedy;
    chk("act_valid", o_action_valid, 1);
    chk("action", o_action, exp_a);
    chk("explore", o_explore, exp_x);
    got = o_action;
    for (int c = 0; c < rdy_wait; c++) begin
      tick();
      chk("bp_valid", o_action_valid, 1);
      chk("bp_action", o_action, exp_a);
      chk("bp_explore", o_explore, exp_x);
    end
    i_action_ready = 1'b1;
    tick();
    i_action_ready = 1'b0;
    chk("xfer_valid", o_action_valid, 0);
    chk("xfer_idle", o_busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_epsilon = '0;
    i_q_valid = 1'b0;
    i_q_addr = '0;
    i_q_data = '0;
    i_am_arg_max = '0;
    i_am_valid = 1'b0;
    i_action_ready = 1'b0;
    repeat (3) tick();
    chk("rst_am_valid", o_am_valid, 0);
    chk("rst_am_addr", o_am_addr, 0);
    chk("rst_am_data", o_am_data, 0);
    chk("rst_action", o_action, 0);
    chk("rst_act_valid", o_action_valid, 0);
    chk("rst_explore", o_explore, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_error", o_error, 0);
    rst = 1'b0;

    // beats and argmax results while idle must be ignored
    i_am_valid = 1'b1;
    beat(1, 32'hDEAD_BEEF, 1'b0);
    i_am_valid = 1'b0;
    chk("idle_busy", o_busy, 0);
    chk("idle_act", o_action_valid, 0);

    // greedy path
    qv = '{32'h3F80_0000, 32'h4040_0000, 32'h4000_0000};
    decide(16'h0000, 2'd1, 2, 0, 1'b0, act);
    chk("greedy_act", act, 1);

    // backpressure
    decide(16'h8000, 2'd2, 0, 10, 1'b0, act);

    // explore with low LFSR bits = 3
    decide(16'hFFFF, 2'd2, 0, 0, 1'b1, act);

    for (int i = 0; i < 1000; i++) begin
      foreach (qv[k]) qv[k] = $urandom;
      decide(16'hFFFF, AW'($urandom_range(0, N - 1)), 0, 0, 1'b0, act);
      hist[act]++;
    end
    for (int a = 0; a < N; a++) chk("hist_nonzero", hist[a] > 0, 1);

    for (int i = 0; i < 200; i++) begin
      foreach (qv[k]) qv[k] = $urandom;
      decide(16'($urandom), AW'($urandom_range(0, N - 1)),
             $urandom_range(0, 5), $urandom_range(0, 3), 1'b0, act);
    end

    // argmax never answers
    start_load(16'h4000);
    for (int c = 1; c < TO; c++) begin
      tick();
      chk("to_busy", o_busy, 1);
      chk("to_act", o_action_valid, 0);
    end
    chk("to_err_early", o_error, 0);
    tick();
    chk("to_err", o_error, 1);
    chk("to_idle", o_busy, 0);
    chk("to_act_end", o_action_valid, 0);
    i_am_valid = 1'b1;
    tick();
    i_am_valid = 1'b0;
    tick();
    chk("late_am_act", o_action_valid, 0);
    chk("late_am_busy", o_busy, 0);
    decide(16'h2000, 2'd0, 1, 1, 1'b0, act);

    // bad address plus start while loading
    i_start = 1'b1;
    i_epsilon = 16'h0000;
    tick();
    i_start = 1'b0;
    beat(0, 32'h1111_1111, 1'b1);
    beat(5, 32'h5555_5555, 1'b0);
    chk("bad_err", o_error, 1);
    i_start = 1'b1;
    i_epsilon = 16'hFFFF;
    tick();
    i_start = 1'b0;
    chk("ign_start_busy", o_busy, 1);
    chk("ign_start_err", o_error, 1);
    beat(1, 32'h2222_2222, 1'b1);
    beat(2, 32'h3333_3333, 1'b1);
    i_am_valid = 1'b1;
    i_am_arg_max = 2'd2;
    tick();
    i_am_valid = 1'b0;
    tick();
    chk("bad_act_valid", o_action_valid, 1);
    chk("bad_action", o_action, 2);
    chk("bad_explore", o_explore, 0);
    i_action_ready = 1'b1;
    tick();
    i_action_ready = 1'b0;
    chk("bad_idle", o_busy, 0);

    // reset while holding an action
    start_load(16'h1234);
    i_am_valid = 1'b1;
    i_am_arg_max = 2'd2;
    tick();
    i_am_valid = 1'b0;
    tick();
    chk("hold_valid", o_action_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_act_valid", o_action_valid, 0);
    chk("mrst_action", o_action, 0);
    chk("mrst_explore", o_explore, 0);
    chk("mrst_am_valid", o_am_valid, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_error", o_error, 0);
    decide(16'hFFFF, 2'd1, 0, 0, 1'b0, act);
    decide(16'h9000, 2'd0, 1, 0, 1'b0, act);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
